// File: rtl/inst_rom_resp.sv
// ----------------------------------------------------------------------------
// inst_rom_resp
//   Loadable instruction ROM. A host streams 32-bit words into the array
//   starting at word 0. Once the load completes, the CPU fetch stage reads
//   instructions combinationally, with zero latency, using its byte PC.
//
//   Optional feature: define INST_ROM_ALIGN_CHK_EN to enable misaligned-fetch
//   detection. When it is enabled, a RUN fetch whose address has a nonzero
//   addr_i[1:0] returns a NOP and sets the sticky align_err_o flag.
//
// Parameters
//   DEPTH_LOG2   log2 of the number of stored instruction words
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous active-high reset
//   ce_i         fetch enable from the CPU fetch stage
//   addr_i       byte fetch address (CPU PC)
//   inst_o       fetched instruction; 32'h0 (NOP) when no fetch is served
//   ld_start_i   host request to begin loading at word 0
//   ld_valid_i   host load beat valid
//   ld_data_i    host load word
//   ld_last_i    marks the final load beat
//   ld_ready_o   high while a load is in progress
//   ld_done_o    one-cycle pulse after the final beat is accepted
//   fetch_cnt_o  saturating count of served fetches
//   align_err_o  sticky misaligned-fetch flag (tied 0 without the feature)
// ----------------------------------------------------------------------------
module inst_rom_resp #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic [31:0] addr_i,
    output logic [31:0] inst_o,
    input  logic        ld_start_i,
    input  logic        ld_valid_i,
    input  logic [31:0] ld_data_i,
    input  logic        ld_last_i,
    output logic        ld_ready_o,
    output logic        ld_done_o,
    output logic [31:0] fetch_cnt_o,
    output logic        align_err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic                  ld_done_q, ld_done_d;
    logic [31:0]           fetch_cnt_q, fetch_cnt_d;

    logic [31:0]           mem [DEPTH];

    logic                  beat_acc;
    logic                  last_beat;
    logic                  fetch_en;
    logic                  misaligned;
    logic [DEPTH_LOG2-1:0] raddr;

    // The upper address bits alias onto the array, so they are intentionally
    // unused.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:DEPTH_LOG2+2];

    assign raddr      = addr_i[DEPTH_LOG2+1:2];
    assign fetch_en   = (state_q == RUN) && ce_i;
    assign ld_ready_o = (state_q == LOAD);
    assign beat_acc   = ld_ready_o && ld_valid_i;
    // The load ends on an explicit last beat or when the array is full.
    // Either condition alone is enough, and both together still cause only
    // one transition.
    assign last_beat  = ld_last_i || (&wptr_q);

`ifdef INST_ROM_ALIGN_CHK_EN
    logic align_err_q, align_err_d;

    assign misaligned  = (addr_i[1:0] != 2'b00);
    assign align_err_d = align_err_q | (fetch_en & misaligned);
    assign align_err_o = align_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) align_err_q <= 1'b0;
        else     align_err_q <= align_err_d;
    end
`else
    logic unused_addr_lo;
    assign unused_addr_lo = ^addr_i[1:0];
    assign misaligned     = 1'b0;
    assign align_err_o    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        ld_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_start_i) begin
                    state_d = LOAD;
                    wptr_d  = '0;
                end
            end
            LOAD: begin
                // A start request during a load is ignored.
                if (beat_acc) begin
                    wptr_d = wptr_q + 1'b1;
                    if (last_beat) begin
                        state_d   = RUN;
                        ld_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (ld_start_i) begin
                    state_d = LOAD;
                    wptr_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (fetch_en && !(&fetch_cnt_q)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            ld_done_q   <= 1'b0;
            fetch_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            ld_done_q   <= ld_done_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // The array is not reset, so words written by an interrupted load persist.
    always_ff @(posedge clk) begin
        if (beat_acc) mem[wptr_q] <= ld_data_i;
    end

    always_comb begin
        inst_o = 32'h0;
        if (fetch_en && !misaligned) inst_o = mem[raddr];
    end

    assign ld_done_o   = ld_done_q;
    assign fetch_cnt_o = fetch_cnt_q;

endmodule

// File: tb/tb_inst_rom_resp.sv
module tb_inst_rom_resp;

`ifdef INST_ROM_ALIGN_CHK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i, ld_start_i, ld_valid_i, ld_last_i;
    logic [31:0] addr_i, ld_data_i;
    logic [31:0] inst_o, fetch_cnt_o;
    logic        ld_ready_o, ld_done_o, align_err_o;

    logic        ce2, ld_start2, ld_valid2, ld_last2;
    logic [31:0] addr2, ld_data2;
    logic [31:0] inst2, fetch_cnt2;
    logic        ld_ready2, ld_done2, align_err2;

    always #5 clk = ~clk;

    inst_rom_resp dut (
        .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(inst_o),
        .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i),
        .ld_last_i(ld_last_i), .ld_ready_o(ld_ready_o), .ld_done_o(ld_done_o),
        .fetch_cnt_o(fetch_cnt_o), .align_err_o(align_err_o)
    );

    inst_rom_resp #(.DEPTH_LOG2(2)) dut2 (
        .clk(clk), .rst(rst), .ce_i(ce2), .addr_i(addr2), .inst_o(inst2),
        .ld_start_i(ld_start2), .ld_valid_i(ld_valid2), .ld_data_i(ld_data2),
        .ld_last_i(ld_last2), .ld_ready_o(ld_ready2), .ld_done_o(ld_done2),
        .fetch_cnt_o(fetch_cnt2), .align_err_o(align_err2)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mdl  [1024];
    logic [31:0] mdl2 [4];
    logic [31:0] sb_q [$];
    int          wp = 0;
    bit          m_run = 1'b0;
    logic [31:0] exp_cnt = 32'd0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        if (m_run && ce_i) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic start1();
        ld_start_i = 1'b1;
        tick();
        ld_start_i = 1'b0;
        wp    = 0;
        m_run = 1'b0;
    endtask

    task automatic beat1(input logic [31:0] d, input logic v, input logic l, input logic s);
        ld_data_i  = d;
        ld_valid_i = v;
        ld_last_i  = l;
        ld_start_i = s;
        tick();
        ld_valid_i = 1'b0;
        ld_last_i  = 1'b0;
        ld_start_i = 1'b0;
        if (v) begin
            mdl[wp] = d;
            wp++;
            if (l) m_run = 1'b1;
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic en);
        logic [31:0] got;
        ce_i   = en;
        addr_i = a;
        if (en && m_run && !(ALIGN_CHK && a[1:0] != 2'b00)) sb_q.push_back(mdl[a[11:2]]);
        else                                                sb_q.push_back(32'h0);
        #2;
        got = inst_o;
        chk("inst", got, sb_q.pop_front());
        tick();
        ce_i = 1'b0;
    endtask

    task automatic fetch2(input logic [31:0] a);
        logic [31:0] got;
        ce2   = 1'b1;
        addr2 = a;
        sb_q.push_back(mdl2[a[3:2]]);
        #2;
        got = inst2;
        chk("inst2", got, sb_q.pop_front());
        tick();
        ce2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ce_i = 1'b0; addr_i = '0; ld_start_i = 1'b0; ld_valid_i = 1'b0;
        ld_data_i = '0; ld_last_i = 1'b0;
        ce2 = 1'b0; addr2 = '0; ld_start2 = 1'b0; ld_valid2 = 1'b0;
        ld_data2 = '0; ld_last2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, with a fetch attempted while IDLE.
        ce_i = 1'b1;
        #1;
        chk("rst_ready", {31'b0, ld_ready_o}, 32'd0);
        chk("rst_cnt", fetch_cnt_o, 32'd0);
        chk("rst_done", {31'b0, ld_done_o}, 32'd0);
        chk("rst_align", {31'b0, align_err_o}, 32'd0);
        fetch(32'h0, 1'b1);

        // Load with a valid gap and a start request that must be ignored.
        start1();
        chk("load_ready", {31'b0, ld_ready_o}, 32'd1);
        beat1(32'h3401_0001, 1'b1, 1'b0, 1'b0);
        beat1(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        beat1(32'h3401_0002, 1'b1, 1'b0, 1'b0);
        beat1(32'h3401_0003, 1'b1, 1'b0, 1'b1);
        chk("start_ignored", {31'b0, ld_ready_o}, 32'd1);
        chk("done_early", {31'b0, ld_done_o}, 32'd0);
        beat1(32'h3401_0004, 1'b1, 1'b1, 1'b0);
        chk("done_pulse", {31'b0, ld_done_o}, 32'd1);
        chk("ready_run", {31'b0, ld_ready_o}, 32'd0);
        tick();
        chk("done_clear", {31'b0, ld_done_o}, 32'd0);

        // Fetches, including an aliased address, followed by two idle cycles.
        fetch(32'h0000_000C, 1'b1);
        fetch(32'h0000_0000, 1'b1);
        fetch(32'h0000_0004, 1'b1);
        fetch(32'h0000_0008, 1'b1);
        fetch(32'h0000_1004, 1'b1);
        fetch(32'h0000_000C, 1'b0);
        fetch(32'h0000_000C, 1'b0);
        chk("fetch_cnt5", fetch_cnt_o, exp_cnt);

        // A misaligned fetch.
        fetch(32'h0000_0002, 1'b1);
        chk("align_set", {31'b0, align_err_o}, {31'b0, ALIGN_CHK});
        fetch(32'h0000_0008, 1'b1);
        chk("align_sticky", {31'b0, align_err_o}, {31'b0, ALIGN_CHK});
        chk("fetch_cnt7", fetch_cnt_o, exp_cnt);

        // Reload from RUN, then reset partway through the load.
        start1();
        fetch(32'h0000_000C, 1'b1);
        beat1(32'hA000_0000, 1'b1, 1'b0, 1'b0);
        beat1(32'hA000_0001, 1'b1, 1'b0, 1'b0);
        ce_i = 1'b1;
        addr_i = 32'h0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'b0, ld_ready_o}, 32'd0);
        chk("mid_rst_inst", inst_o, 32'h0);
        chk("mid_rst_cnt", fetch_cnt_o, 32'd0);
        chk("mid_rst_align", {31'b0, align_err_o}, 32'd0);
        chk("mid_rst_done", {31'b0, ld_done_o}, 32'd0);
        ce_i = 1'b0;
        m_run = 1'b0;
        exp_cnt = 32'd0;
        tick();
        rst = 1'b0;

        // Words from the abandoned load persist.
        start1();
        beat1(32'hB000_0000, 1'b1, 1'b1, 1'b0);
        fetch(32'h0, 1'b1);
        fetch(32'h4, 1'b1);
        fetch(32'h8, 1'b1);
        fetch(32'hC, 1'b1);
        chk("fetch_cnt_post", fetch_cnt_o, exp_cnt);

        // Small instance: the load fills without a last beat and addresses alias.
        ld_start2 = 1'b1;
        tick();
        ld_start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("d2_ready", {31'b0, ld_ready2}, 32'd1);
            ld_valid2 = 1'b1;
            ld_data2  = 32'hC000_0000 + i;
            tick();
            mdl2[i] = 32'hC000_0000 + i;
        end
        ld_valid2 = 1'b0;
        chk("d2_done", {31'b0, ld_done2}, 32'd1);
        chk("d2_run", {31'b0, ld_ready2}, 32'd0);
        fetch2(32'h0000_0010);
        fetch2(32'h0000_000C);
        fetch2(32'h0000_0034);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_rom_resp.md
INST_ROM_RESP -- requirements
Module: inst_rom_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of the number of 32-bit instruction words stored (1024).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port ce_i  input  1  fetch enable from the CPU fetch stage.
REQ-005 SHALL have port addr_i  input  32  byte fetch address from the CPU PC.
REQ-006 SHALL have port inst_o  output  32  instruction word returned to the CPU.
REQ-007 SHALL have port ld_start_i  input  1  host request to begin loading at word 0.
REQ-008 SHALL have port ld_valid_i  input  1  host load beat valid.
REQ-009 SHALL have port ld_data_i  input  32  host load word.
REQ-010 SHALL have port ld_last_i  input  1  marks the final load beat.
REQ-011 SHALL have port ld_ready_o  output  1  responder accepts a load beat.
REQ-012 SHALL have port ld_done_o  output  1  one-cycle pulse when a load completes.
REQ-013 SHALL have port fetch_cnt_o  output  32  count of served fetches.
REQ-014 SHALL have port align_err_o  output  1  sticky misaligned-fetch flag.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN; IDLE entered on reset.
REQ-016 Transition IDLE->LOAD or RUN->LOAD SHALL occur on the edge where ld_start_i=1, clearing write pointer wptr to 0.
REQ-017 ld_start_i in LOAD SHALL be ignored.
REQ-018 ld_ready_o SHALL be 1 only in LOAD, combinationally from state.
REQ-019 A beat SHALL be accepted on the edge where ld_valid_i and ld_ready_o are both 1: mem[wptr] <= ld_data_i, wptr <= wptr+1.
REQ-020 LOAD->RUN SHALL occur on the edge accepting a beat with ld_last_i=1 or with wptr=2^DEPTH_LOG2-1 (both together: one transition, no wrap write).
REQ-021 ld_done_o SHALL be registered, 1 for exactly the cycle following the LOAD->RUN edge.
REQ-022 Fetch read SHALL be combinational (zero latency) so the CPU fetch/decode register latches inst_o in the same cycle addr_i is presented.
REQ-023 In RUN with ce_i=1, inst_o SHALL equal mem[addr_i[DEPTH_LOG2+1:2]]; addr_i bits above DEPTH_LOG2+1 are ignored (aliasing wrap).
REQ-024 inst_o SHALL be 32'h0 (NOP) when ce_i=0 or state is IDLE or LOAD.
REQ-025 fetch_cnt_o SHALL increment by 1 each edge in RUN with ce_i=1, saturating at 32'hFFFF_FFFF; cleared only by reset.
REQ-026 Words not written since power-up SHALL read as undefined; bench preloads before RUN fetches.

Reset
REQ-027 On rst=1, asynchronously: state=IDLE, wptr=0, ld_done_o=0, fetch_cnt_o=0, align_err_o=0; ld_ready_o=0 and inst_o=0 follow.
REQ-028 Memory array contents SHALL NOT be reset; reset mid-LOAD abandons the load, written words persist.

Configuration
REQ-029 Macro INST_ROM_ALIGN_CHK_EN: when defined, a RUN fetch with ce_i=1 and addr_i[1:0]!=0 SHALL force inst_o=0 and set align_err_o to 1 (sticky until reset) on that edge.
REQ-030 When INST_ROM_ALIGN_CHK_EN is undefined, addr_i[1:0] SHALL be ignored and align_err_o tied 0.

Verification
REQ-031 Reset, then ce_i=1, addr_i=0 -> inst_o=0, ld_ready_o=0, fetch_cnt_o=0.
REQ-032 ld_start_i pulse, load 4 beats 32'h3401_0001..32'h3401_0004 with last on beat 4 -> ld_done_o pulses once, then addr_i=0x0C returns 32'h3401_0004.
REQ-033 ld_valid_i toggled 1,0,1 while loading -> only valid beats written, wptr advances twice.
REQ-034 DEPTH_LOG2=2, load 4 beats without ld_last_i -> RUN after beat 4; addr_i=0x10 returns word 0.
REQ-035 RUN, ce_i=1 for 5 cycles, ce_i=0 for 2 -> fetch_cnt_o=5.
REQ-036 With INST_ROM_ALIGN_CHK_EN, addr_i=0x02 in RUN -> inst_o=0, align_err_o=1 held; assert rst mid-LOAD -> state IDLE immediately, align_err_o=0.
